// File: rtl/exp_core_sequencer_if.sv
// Sample-in / result-out handshakes plus the exponent-core input/output pair.
// master is the sequencer's view, slave is the surrounding source/sink/core.
interface exp_core_sequencer_if #(
    parameter int INT_WIDTH       = 4,
    parameter int FRAC_WIDTH      = 4,
    parameter int CORE_INT_WIDTH  = 17,
    parameter int CORE_FRAC_WIDTH = 28,
    parameter int OUT_INT_WIDTH   = 8,
    parameter int OUT_FRAC_WIDTH  = 8,
    parameter int CNT_WIDTH       = 16
);
    logic [INT_WIDTH+FRAC_WIDTH-1:0]           s_data;
    logic                                      s_valid;
    logic                                      s_ready;
    logic [INT_WIDTH+FRAC_WIDTH-1:0]           core_inp;
    logic [CORE_INT_WIDTH+CORE_FRAC_WIDTH-1:0] core_outp;
    logic [OUT_INT_WIDTH+OUT_FRAC_WIDTH-1:0]   m_data;
    logic                                      m_sat;
    logic                                      m_valid;
    logic                                      m_ready;
    logic                                      busy;
    logic [CNT_WIDTH-1:0]                      done_count;

    modport master (
        input  s_data, s_valid, core_outp, m_ready,
        output s_ready, core_inp, m_data, m_sat, m_valid, busy, done_count
    );

    modport slave (
        output s_data, s_valid, core_outp, m_ready,
        input  s_ready, core_inp, m_data, m_sat, m_valid, busy, done_count
    );
endinterface

// File: rtl/exp_core_sequencer.sv
// Holds each Q4.4 sample on the exponent core for CORE_LATENCY+1 edges, then rounds/saturates
// the Q17.28 result to Q8.8; result held until m_ready, no new sample accepted while busy.
module exp_core_sequencer #(
    parameter int INT_WIDTH       = 4,
    parameter int FRAC_WIDTH      = 4,
    parameter int CORE_INT_WIDTH  = 17,
    parameter int CORE_FRAC_WIDTH = 28,
    parameter int CORE_LATENCY    = 12,
    parameter int OUT_INT_WIDTH   = 8,
    parameter int OUT_FRAC_WIDTH  = 8,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    exp_core_sequencer_if.master bus
);
    localparam int CORE_W = CORE_INT_WIDTH + CORE_FRAC_WIDTH;
    localparam int OUT_W  = OUT_INT_WIDTH + OUT_FRAC_WIDTH;
    localparam int LSB    = CORE_FRAC_WIDTH - OUT_FRAC_WIDTH;
    localparam int WAIT_W = $clog2(CORE_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic [OUT_W-1:0]        trunc;
    logic                    round_bit;
    logic [CORE_W-1:LSB+OUT_W] upper;
    logic [OUT_W:0]          rounded;
    logic                    sat;
    logic                    unused_low;

    // Bits below the round position never influence the result.
    assign trunc      = bus.core_outp[LSB+OUT_W-1:LSB];
    assign round_bit  = bus.core_outp[LSB-1];
    assign upper      = bus.core_outp[CORE_W-1:LSB+OUT_W];
    assign unused_low = ^bus.core_outp[LSB-2:0];
    assign rounded    = {1'b0, trunc} + (OUT_W+1)'(round_bit);
    assign sat        = (|upper) | rounded[OUT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            bus.core_inp   <= '0;
            bus.m_data     <= '0;
            bus.m_sat      <= 1'b0;
            bus.m_valid    <= 1'b0;
            bus.s_ready    <= 1'b1;
            bus.busy       <= 1'b0;
            bus.done_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.s_valid) begin
                        bus.core_inp <= bus.s_data;
                        wait_cnt     <= WAIT_W'(CORE_LATENCY);
                        bus.s_ready  <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The core output is only trusted once the counter has drained.
                    if (wait_cnt == '0) begin
                        bus.m_data  <= sat ? '1 : rounded[OUT_W-1:0];
                        bus.m_sat   <= sat;
                        bus.m_valid <= 1'b1;
                        state       <= ST_OUT;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (bus.m_ready) begin
                        bus.m_valid    <= 1'b0;
                        bus.done_count <= bus.done_count + CNT_WIDTH'(1);
                        bus.s_ready    <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    bus.m_valid <= 1'b0;
                    bus.s_ready <= 1'b1;
                    bus.busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exp_core_sequencer.sv
// Directed bench: table of core results with hand-computed Q8.8 outputs, plus hold/reset/wrap sequences.
module tb_exp_core_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exp_core_sequencer_if bus();
    exp_core_sequencer_if #(.CNT_WIDTH(4)) bus2();

    exp_core_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_core_sequencer #(.CNT_WIDTH(4)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Core stub answers only for the expected sample; anything else reads back as 0x1234.
    localparam logic [44:0] SENTINEL = 45'h0_0001_2340_0000;
    logic [7:0]  stub_key;
    logic [44:0] stub_val;
    assign bus.core_outp  = (bus.core_inp == stub_key) ? stub_val : SENTINEL;
    assign bus2.core_outp = 45'h0_0000_1000_0000;

    int total = 0;
    int bad   = 0;
    int exp_done = 0;

    typedef struct {
        logic [7:0]  sample;
        logic [44:0] core;
        logic [15:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input string name, output int n);
        n = 0;
        while (!bus.m_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake(input string name);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        exp_done++;
        check({name, " m_valid_after_hs"}, bus.m_valid, 1'b0);
        check({name, " done_count"}, bus.done_count, exp_done);
        check({name, " s_ready_after_hs"}, bus.s_ready, 1'b1);
    endtask

    task automatic run_sample(input string name, input logic [7:0] samp, input logic [44:0] core,
                              input logic [15:0] ed, input logic es);
        int n;
        stub_key    = samp;
        stub_val    = core;
        bus.s_data  = samp;
        bus.s_valid = 1'b1;
        check({name, " s_ready_idle"}, bus.s_ready, 1'b1);
        tick();
        bus.s_valid = 1'b0;
        check({name, " s_ready_wait"}, bus.s_ready, 1'b0);
        check({name, " busy"}, bus.busy, 1'b1);
        check({name, " core_inp"}, bus.core_inp, samp);
        wait_result(name, n);
        check({name, " latency"}, n, 13);
        check({name, " m_data"}, bus.m_data, ed);
        check({name, " m_sat"}, bus.m_sat, es);
        handshake(name);
    endtask

    initial begin
        int n;
        int cyc, last_acc, min_sp, max_sp, hs;
        logic will_acc, will_hs;

        vecs[0] = '{8'h10, 45'h0_0000_1000_0000, 16'h0100, 1'b0};
        vecs[1] = '{8'h11, 45'h0_0000_000C_0000, 16'h0001, 1'b0};
        vecs[2] = '{8'h12, 45'h0_0000_0180_0000, 16'h0018, 1'b0};
        vecs[3] = '{8'h13, 45'h0_0000_0007_FFFF, 16'h0000, 1'b0};
        vecs[4] = '{8'h14, 45'h0_0010_0000_0000, 16'hFFFF, 1'b1};
        vecs[5] = '{8'h15, 45'h0_000F_FFF8_0000, 16'hFFFF, 1'b1};
        vecs[6] = '{8'h16, 45'h0_000F_FFF0_0000, 16'hFFFF, 1'b0};
        vecs[7] = '{8'h17, 45'h0_000F_FFE8_0000, 16'hFFFF, 1'b0};
        vecs[8] = '{8'h18, 45'h0_0000_0FF8_0000, 16'h0100, 1'b0};
        vecs[9] = '{8'h19, 45'h1000_0000_0000,   16'hFFFF, 1'b1};

        rst = 1'b1;
        bus.s_data = '0;  bus.s_valid = 1'b0;  bus.m_ready = 1'b0;
        bus2.s_data = 8'h10; bus2.s_valid = 1'b0; bus2.m_ready = 1'b0;
        stub_key = '0;
        stub_val = '0;
        tick();
        tick();
        check("rst s_ready", bus.s_ready, 1'b1);
        check("rst m_valid", bus.m_valid, 1'b0);
        check("rst m_data", bus.m_data, 16'h0000);
        check("rst m_sat", bus.m_sat, 1'b0);
        check("rst core_inp", bus.core_inp, 8'h00);
        check("rst done_count", bus.done_count, 16'd0);
        check("rst busy", bus.busy, 1'b0);
        rst = 1'b0;

        // m_ready without a pending result must not count anything.
        bus.m_ready = 1'b1;
        repeat (3) tick();
        bus.m_ready = 1'b0;
        check("idle m_ready done_count", bus.done_count, 16'd0);
        check("idle m_ready m_valid", bus.m_valid, 1'b0);

        for (int i = 0; i < 10; i++)
            run_sample($sformatf("vec%0d", i), vecs[i].sample, vecs[i].core, vecs[i].exp_data, vecs[i].exp_sat);

        // Output held under backpressure while the source keeps offering new data.
        stub_key    = 8'h21;
        stub_val    = 45'h0_0000_2348_0000;
        bus.s_data  = 8'h21;
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        wait_result("hold", n);
        check("hold latency", n, 13);
        for (int i = 0; i < 20; i++) begin
            bus.s_valid = i[0];
            bus.s_data  = 8'h40 + 8'(i);
            tick();
            check($sformatf("hold m_data c%0d", i), bus.m_data, 16'h0235);
            check($sformatf("hold s_ready c%0d", i), bus.s_ready, 1'b0);
            check($sformatf("hold core_inp c%0d", i), bus.core_inp, 8'h21);
        end
        stub_key    = 8'h33;
        stub_val    = 45'h0_0000_1000_0000;
        bus.s_data  = 8'h33;
        bus.s_valid = 1'b1;
        handshake("hold_release");
        tick();
        bus.s_valid = 1'b0;
        check("next accept s_ready", bus.s_ready, 1'b0);
        check("next accept core_inp", bus.core_inp, 8'h33);
        wait_result("next", n);
        check("next latency", n, 13);
        check("next m_data", bus.m_data, 16'h0100);
        handshake("next");

        // Reset in the middle of WAIT discards the evaluation.
        stub_key    = 8'h55;
        stub_val    = 45'h0_0000_3000_0000;
        bus.s_data  = 8'h55;
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_done = 0;
        check("midrst s_ready", bus.s_ready, 1'b1);
        check("midrst m_valid", bus.m_valid, 1'b0);
        check("midrst core_inp", bus.core_inp, 8'h00);
        check("midrst done_count", bus.done_count, 16'd0);
        check("midrst busy", bus.busy, 1'b0);
        run_sample("post_rst", 8'h55, 45'h0_0000_3000_0000, 16'h0300, 1'b0);

        // Streaming on the narrow-counter instance: 18 results wrap a 4-bit count to 2.
        bus2.s_valid = 1'b1;
        bus2.m_ready = 1'b1;
        cyc = 0; last_acc = -1; min_sp = 1000; max_sp = 0; hs = 0;
        while (hs < 18 && cyc < 600) begin
            will_acc = bus2.s_ready & bus2.s_valid;
            will_hs  = bus2.m_valid;
            tick();
            cyc++;
            if (will_acc) begin
                if (last_acc >= 0) begin
                    if (cyc - last_acc < min_sp) min_sp = cyc - last_acc;
                    if (cyc - last_acc > max_sp) max_sp = cyc - last_acc;
                end
                last_acc = cyc;
            end
            if (will_hs) hs++;
        end
        bus2.s_valid = 1'b0;
        check("wrap handshakes", hs, 18);
        check("wrap done_count", bus2.done_count, 4'd2);
        check("wrap min spacing", min_sp, 15);
        check("wrap max spacing", max_sp, 15);
        check("wrap m_data", bus2.m_data, 16'h0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
